// File: rtl/adder_display_pkg.sv
// Shared types, segment encodings and default timing for the adder result display.
package adder_display_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_BLINK_CYCLES    = 25000000;

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_SHOW,
    ST_OVF
  } disp_state_t;

  // Active-low segments, bit order {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_O     = 8'hC0;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_S     = 8'h92;

  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      default: return SEG_BLANK;
    endcase
  endfunction

  // -8 negates to 4'b1000, read unsigned as 8, so no wrap handling is needed
  function automatic logic [3:0] magnitude(input logic [3:0] v);
    return v[3] ? (~v + 4'd1) : v;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer, counter debounce and one-cycle press pulse on the debounced 1->0 edge.
// After reset the button must be seen released for a full debounce window before presses count.
module button_debounce
  import adder_display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          armed;
  logic [CW-1:0] cnt;
  logic          differ;

  // Until armed, only a stable release is of interest
  assign differ = armed ? (sync2 != level) : sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      armed <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= button_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (!differ) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        if (armed) begin
          level <= sync2;
          press <= ~sync2;
        end else begin
          armed <= 1'b1;
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/adder_result_display.sv
// Captures the upstream adder result on a debounced button press and shows it on three 7-seg digits.
// Display lags the capture by one cycle; OVF_BLINK_EN makes the overflow "OF" blink.
module adder_result_display
  import adder_display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int BLINK_CYCLES    = DEF_BLINK_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sum,
  input  logic       overflow,
  input  logic       sub_mode,
  input  logic       capture_n,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX2,
  output logic       result_valid,
  output logic [3:0] capture_count
);

  logic        capture;
  disp_state_t state;
  logic [3:0]  cap_sum;
  logic        cap_sub;
  logic        blink_on;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .button_n (capture_n),
    .press    (capture)
  );

`ifdef OVF_BLINK_EN
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  logic [BW-1:0] blink_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (capture) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (state == ST_OVF) begin
      if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end
`else
  // Steady "OF"
  assign blink_on = (BLINK_CYCLES != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_BLANK;
      cap_sum       <= '0;
      cap_sub       <= 1'b0;
      capture_count <= '0;
      HEX0          <= SEG_BLANK;
      HEX1          <= SEG_BLANK;
      HEX2          <= SEG_BLANK;
      result_valid  <= 1'b0;
    end else begin
      if (capture) begin
        state         <= overflow ? ST_OVF : ST_SHOW;
        cap_sum       <= sum;
        cap_sub       <= sub_mode;
        capture_count <= capture_count + 4'd1;
      end
      case (state)
        ST_SHOW: begin
          HEX0         <= seg_digit(magnitude(cap_sum));
          HEX1         <= cap_sum[3] ? SEG_MINUS : SEG_BLANK;
          HEX2         <= cap_sub ? SEG_S : SEG_A;
          result_valid <= 1'b1;
        end
        ST_OVF: begin
          HEX0         <= blink_on ? SEG_F : SEG_BLANK;
          HEX1         <= blink_on ? SEG_O : SEG_BLANK;
          HEX2         <= cap_sub ? SEG_S : SEG_A;
          result_valid <= 1'b1;
        end
        default: begin
          HEX0         <= SEG_BLANK;
          HEX1         <= SEG_BLANK;
          HEX2         <= SEG_BLANK;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_result_display.sv
// Scoreboard bench: expected display pushed per press, popped when capture_count advances.
module tb_adder_result_display;

  localparam int DB = 8;
  localparam int BL = 4;
`ifdef OVF_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sum;
  logic       overflow;
  logic       sub_mode;
  logic       capture_n;
  logic [7:0] hex0, hex1, hex2;
  logic       result_valid;
  logic [3:0] capture_count;

  always #5 clk = ~clk;

  adder_result_display #(.DEBOUNCE_CYCLES(DB), .BLINK_CYCLES(BL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sum           (sum),
    .overflow      (overflow),
    .sub_mode      (sub_mode),
    .capture_n     (capture_n),
    .HEX0          (hex0),
    .HEX1          (hex1),
    .HEX2          (hex2),
    .result_valid  (result_valid),
    .capture_count (capture_count)
  );

  typedef struct packed {
    logic [7:0] h0;
    logic [7:0] h1;
    logic [7:0] h2;
    logic       vld;
    logic [3:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] exp_count = 4'd0;
  logic [7:0] seg_tab [0:8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] s, input logic o, input logic sub, input logic [3:0] c);
    exp_t e;
    int   v;
    int   mag;
    v     = $signed(s);
    mag   = (v < 0) ? -v : v;
    e.h2  = sub ? 8'h92 : 8'h88;
    e.vld = 1'b1;
    e.cnt = c;
    e.ovf = o;
    if (o) begin
      e.h1 = 8'hC0;
      e.h0 = 8'h8E;
    end else begin
      e.h1 = (v < 0) ? 8'hBF : 8'hFF;
      e.h0 = seg_tab[mag];
    end
    return e;
  endfunction

  task automatic press(input logic [3:0] s, input logic o, input logic sub, input int bounces);
    exp_t       e;
    logic [3:0] prev;
    bit         seen;
    bit         vis;
    sum       = s;
    overflow  = o;
    sub_mode  = sub;
    exp_count = exp_count + 4'd1;
    sb.push_back(model(s, o, sub, exp_count));
    prev = capture_count;
    for (int i = 0; i < bounces; i++) begin
      capture_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    capture_n = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 3 * DB + 10; k++) begin
      @(negedge clk);
      if (capture_count !== prev) begin
        seen = 1'b1;
        break;
      end
    end
    check("event_seen", 32'(seen), 32'd1);
    e = sb.pop_front();
    if (seen) begin
      @(negedge clk);
      check("hex0", 32'(hex0), 32'(e.h0));
      check("hex1", 32'(hex1), 32'(e.h1));
      check("hex2", 32'(hex2), 32'(e.h2));
      check("valid", 32'(result_valid), 32'(e.vld));
      check("count", 32'(capture_count), 32'(e.cnt));
      if (o && BLINK) begin
        for (int k = 1; k < 16; k++) begin
          @(negedge clk);
          vis = ((k / BL) % 2) == 0;
          check("blink_hex1", 32'(hex1), vis ? 32'hC0 : 32'hFF);
          check("blink_hex0", 32'(hex0), vis ? 32'h8E : 32'hFF);
        end
      end
    end
    // Upstream activity between events must not leak through
    sum      = 4'($urandom);
    overflow = 1'($urandom);
    sub_mode = 1'($urandom);
    repeat (5) @(negedge clk);
    check("hold_hex2", 32'(hex2), 32'(e.h2));
    check("hold_valid", 32'(result_valid), 32'(e.vld));
    if (!(e.ovf && BLINK)) begin
      check("hold_hex0", 32'(hex0), 32'(e.h0));
      check("hold_hex1", 32'(hex1), 32'(e.h1));
    end
    capture_n = 1'b1;
    repeat (DB + 8) @(negedge clk);
    check("no_release_event", 32'(capture_count), 32'(exp_count));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n     = 1'b0;
    capture_n = 1'b1;
    sum       = 4'd0;
    overflow  = 1'b0;
    sub_mode  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hex0", 32'(hex0), 32'hFF);
    check("rst_hex1", 32'(hex1), 32'hFF);
    check("rst_hex2", 32'(hex2), 32'hFF);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_count", 32'(capture_count), 32'd0);
    rst_n = 1'b1;
    repeat (DB + 6) @(negedge clk);

    press(4'b0011, 1'b0, 1'b0, 0);
    press(4'b1000, 1'b0, 1'b1, 0);
    press(4'b1111, 1'b0, 1'b0, 0);
    press(4'b0111, 1'b1, 1'b1, 0);
    press(4'b0101, 1'b0, 1'b1, 10);
    press(4'b0000, 1'b0, 1'b0, 0);
    press(4'b1001, 1'b1, 1'b0, 0);

    // Asynchronous reset mid-run, checked before the next rising edge
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_hex0", 32'(hex0), 32'hFF);
    check("async_rst_hex1", 32'(hex1), 32'hFF);
    check("async_rst_hex2", 32'(hex2), 32'hFF);
    check("async_rst_valid", 32'(result_valid), 32'd0);
    check("async_rst_count", 32'(capture_count), 32'd0);
    exp_count = 4'd0;

    // Release reset with the button already held
    capture_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * DB + 10) @(negedge clk);
    check("held_through_reset_count", 32'(capture_count), 32'd0);
    check("held_through_reset_valid", 32'(result_valid), 32'd0);
    capture_n = 1'b1;
    repeat (DB + 6) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      press(4'(i), 1'(i % 5 == 4), 1'(i % 3 == 0), 0);
    end
    check("wrap_count", 32'(capture_count), 32'd0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adder_result_display.md
ADDER_RESULT_DISPLAY -- requirements
Module: adder_result_display

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, stable-input cycles needed to accept a button level (10 ms at 50 MHz).
REQ-002 Parameter BLINK_CYCLES, default 25000000, half-period of the overflow blink.
REQ-003 clk  in  1  single system clock (50 MHz board clock); all state on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 sum  in  4  two's-complement result from the upstream four-bit adder/subtractor.
REQ-006 overflow  in  1  signed-overflow flag from the upstream adder.
REQ-007 sub_mode  in  1  1 = upstream is subtracting, 0 = adding.
REQ-008 capture_n  in  1  raw, asynchronous, bouncing push-button, active-low.
REQ-009 HEX0, HEX1, HEX2  out  8 each  seven-segment, active-low, bit order {dp,g,f,e,d,c,b,a}.
REQ-010 result_valid  out  1  high while a captured result is displayed.
REQ-011 capture_count  out  4  number of accepted captures, modulo 16.

Function
REQ-012 capture_n SHALL pass a 2-flop synchronizer before any other use.
REQ-013 Debounce: counter resets on any change of the synchronized level; the debounced level SHALL update only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-014 A capture event SHALL be one-cycle, on the debounced 1->0 transition only; release and held button SHALL produce no event.
REQ-015 On the capture event cycle, sum, overflow, sub_mode SHALL be registered; displays and result_valid update on the following edge (1-cycle latency from event).
REQ-016 FSM states: BLANK (reset), SHOW, OVF. Any state -> OVF on event with overflow=1; any state -> SHOW on event with overflow=0; no other transitions.
REQ-017 BLANK: HEX0..HEX2 = 8'hFF, result_valid = 0.
REQ-018 SHOW: sign = captured sum[3]; magnitude = sum when sign 0, else 4-bit two's-complement negation (sum = 4'b1000 -> magnitude 8, no wrap).
REQ-019 SHOW: HEX0 = digit of magnitude (0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80 hex); HEX1 = 8'hBF if negative else 8'hFF.
REQ-020 SHOW and OVF: HEX2 = 8'h92 ("S") if captured sub_mode else 8'h88 ("A").
REQ-021 OVF: HEX1 = 8'hC0 ("O"), HEX0 = 8'h8E ("F"); result_valid = 1.
REQ-022 capture_count SHALL increment on every capture event, 15 wraps to 0.
REQ-023 Upstream inputs changing between events SHALL NOT affect outputs.
REQ-024 All outputs SHALL be registered; no combinational path from input to output.

Reset
REQ-025 rst_n low SHALL immediately force: state BLANK, HEX0..HEX2 = 8'hFF, result_valid = 0, capture_count = 0, debounced level = 1, synchronizer flops = 1, all counters = 0.
REQ-026 Reset released mid-press SHALL NOT generate an event until a full release/press cycle is debounced.

Configuration
REQ-027 Macro OVF_BLINK_EN: when defined, in OVF HEX0/HEX1 SHALL alternate between "OF" and 8'hFF every BLINK_CYCLES, starting visible on entry; when undefined, "OF" is steady and no blink counter exists.

Structure
REQ-028 Shared package adder_display_pkg holds the FSM state enum, the segment constants for 0-8, blank, minus, O, F, A, S, and the default parameter values.
REQ-029 One sub-module, button_debounce (synchronizer, debounce, falling-edge pulse), instantiated once.

Verification
REQ-030 Reset: rst_n low mid-run -> all HEX = FF, result_valid 0, capture_count 0 asynchronously.
REQ-031 sum=4'b0011, overflow 0, sub_mode 0, clean press -> HEX0 B0, HEX1 FF, HEX2 88, count 1.
REQ-032 sum=4'b1000, sub_mode 1 -> HEX0 80, HEX1 BF, HEX2 92.
REQ-033 overflow=1 with OVF_BLINK_EN, BLINK_CYCLES=4 -> HEX1/HEX0 C0/8E for 4 cycles, FF/FF for 4, repeating.
REQ-034 Press bouncing 10 times within DEBOUNCE_CYCLES=8 then held -> exactly one event, count +1; 16 clean presses -> count returns to 0.
